comb_tdm: RTL and testbench

- Next-generation CIC comb stage: time-multiplexed across NUM_CH independent channels.
- Differential delay is runtime-selectable, 1..CIC_M_MAX.
- Per channel, computes y[n] = x[n] - x[n-M], where x[n-M] is that channel's own sample M strobes earlier.
- Sits between the rate-change stage and the next comb stage (or output) of a multi-channel decimator. Adds channel tagging, synchronous history clear, priming status and a channel-error flag.

---
 rtl/comb_tdm.sv | 165 ++++++++++++++++
 tb/tb_comb_tdm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/comb_tdm.sv
// comb_tdm: time-multiplexed CIC comb stage, y[n] = x[n] - x[n-M] per channel.
// Each channel owns a ring of CIC_M_MAX past samples. The differential delay M
// (m_eff) is loaded only on clr. Channel state is selected with constant-index
// loops, so a channel count that is not a power of two never indexes past the
// end of an array.
module comb_tdm #(
   parameter int unsigned SAMP_WIDTH = 16,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned CIC_M_MAX  = 2,
   parameter int unsigned USE_DSP    = 1,
   localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned M_W       = $clog2(CIC_M_MAX + 1)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic signed [SAMP_WIDTH-1:0] samp_inp_data,
   input  logic        [CH_W-1:0]       samp_inp_ch,
   input  logic                         samp_inp_str,
   input  logic        [M_W-1:0]        cic_m_sel,
   input  logic                         clr,
   output logic signed [SAMP_WIDTH-1:0] samp_out_data,
   output logic        [CH_W-1:0]       samp_out_ch,
   output logic                         samp_out_str,
   output logic                         samp_out_primed,
   output logic                         err_ch
);

   localparam int unsigned PW = (CIC_M_MAX > 1) ? $clog2(CIC_M_MAX) : 1;

   logic signed [SAMP_WIDTH-1:0] ring_q [NUM_CH][CIC_M_MAX];
   logic        [PW-1:0]         wptr_q [NUM_CH];
   logic        [M_W-1:0]        prime_q [NUM_CH];
   logic        [M_W-1:0]        m_eff_q;

   logic                         ch_ok;
   logic                         accept;
   logic        [PW-1:0]         sel_wptr;
   logic        [M_W-1:0]        sel_prime;
   logic        [PW-1:0]         rd_idx;
   logic signed [SAMP_WIDTH-1:0] rd_word;
   logic        [PW-1:0]         wptr_nxt;
   logic        [M_W-1:0]        prime_nxt;
   logic                         primed;
   logic        [M_W-1:0]        m_clamped;
   logic signed [SAMP_WIDTH-1:0] diff;

   assign ch_ok  = 32'(samp_inp_ch) < NUM_CH;
   assign accept = samp_inp_str & ~clr & ch_ok;

   // Pick the addressed channel's pointer and prime count.
   always_comb begin
      sel_wptr  = '0;
      sel_prime = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (32'(samp_inp_ch) == c) begin
            sel_wptr  = wptr_q[c];
            sel_prime = prime_q[c];
         end
      end
   end

   // Read index (wptr - m_eff) mod CIC_M_MAX with an explicit wrap, plus next pointer/prime.
   always_comb begin
      if (32'(sel_wptr) >= 32'(m_eff_q)) begin
         rd_idx = PW'(32'(sel_wptr) - 32'(m_eff_q));
      end else begin
         rd_idx = PW'(32'(sel_wptr) + CIC_M_MAX - 32'(m_eff_q));
      end
      wptr_nxt  = (32'(sel_wptr) == CIC_M_MAX - 1) ? '0 : sel_wptr + PW'(1);
      prime_nxt = (32'(sel_prime) >= CIC_M_MAX) ? sel_prime : sel_prime + M_W'(1);
      primed    = sel_prime >= m_eff_q;
   end

   // Fetch the delayed history word for the addressed channel.
   always_comb begin
      rd_word = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         for (int unsigned k = 0; k < CIC_M_MAX; k++) begin
            if ((32'(samp_inp_ch) == c) && (32'(rd_idx) == k)) begin
               rd_word = ring_q[c][k];
            end
         end
      end
   end

   // Clamp the requested delay into 1..CIC_M_MAX.
   always_comb begin
      if (cic_m_sel == '0) begin
         m_clamped = M_W'(1);
      end else if (32'(cic_m_sel) > CIC_M_MAX) begin
         m_clamped = M_W'(CIC_M_MAX);
      end else begin
         m_clamped = cic_m_sel;
      end
   end

   // Wrapping subtractor, optionally tagged for DSP mapping.
   if (USE_DSP != 0) begin : g_dsp
      (* use_dsp = "yes" *) logic signed [SAMP_WIDTH-1:0] diff_dsp;
      assign diff_dsp = samp_inp_data - rd_word;
      assign diff     = diff_dsp;
   end else begin : g_fabric
      assign diff = samp_inp_data - rd_word;
   end

   // History, pointers, prime counters, delay and error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned k = 0; k < CIC_M_MAX; k++) begin
               ring_q[c][k] <= '0;
            end
            wptr_q[c]  <= '0;
            prime_q[c] <= '0;
         end
         m_eff_q <= M_W'(CIC_M_MAX);
         err_ch  <= 1'b0;
      end else if (clr) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned k = 0; k < CIC_M_MAX; k++) begin
               ring_q[c][k] <= '0;
            end
            wptr_q[c]  <= '0;
            prime_q[c] <= '0;
         end
         m_eff_q <= m_clamped;
         err_ch  <= 1'b0;
      end else begin
         if (samp_inp_str && !ch_ok) begin
            err_ch <= 1'b1;
         end
         if (accept) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
               if (32'(samp_inp_ch) == c) begin
                  for (int unsigned k = 0; k < CIC_M_MAX; k++) begin
                     if (32'(sel_wptr) == k) begin
                        ring_q[c][k] <= samp_inp_data;
                     end
                  end
                  wptr_q[c]  <= wptr_nxt;
                  prime_q[c] <= prime_nxt;
               end
            end
         end
      end
   end

   // Output register; data, tag and primed hold when nothing is accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         samp_out_data   <= '0;
         samp_out_ch     <= '0;
         samp_out_str    <= 1'b0;
         samp_out_primed <= 1'b0;
      end else if (accept) begin
         samp_out_data   <= diff;
         samp_out_ch     <= samp_inp_ch;
         samp_out_str    <= 1'b1;
         samp_out_primed <= primed;
      end else begin
         samp_out_str <= 1'b0;
      end
   end

endmodule

// File: tb/tb_comb_tdm.sv
// tb_comb_tdm: directed and random stimulus on an 8-bit, 3-channel, M_MAX=5 comb,
// checked against a reference that keeps each channel's full sample history.
module tb_comb_tdm;

   localparam int W    = 8;
   localparam int NCH  = 3;
   localparam int MMAX = 5;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic signed [7:0] samp_inp_data = '0;
   logic        [1:0] samp_inp_ch = '0;
   logic              samp_inp_str = 1'b0;
   logic        [2:0] cic_m_sel = '0;
   logic              clr = 1'b0;
   logic signed [7:0] samp_out_data;
   logic        [1:0] samp_out_ch;
   logic              samp_out_str;
   logic              samp_out_primed;
   logic              err_ch;

   comb_tdm #(
      .SAMP_WIDTH (W),
      .NUM_CH     (NCH),
      .CIC_M_MAX  (MMAX),
      .USE_DSP    (1)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .samp_inp_data   (samp_inp_data),
      .samp_inp_ch     (samp_inp_ch),
      .samp_inp_str    (samp_inp_str),
      .cic_m_sel       (cic_m_sel),
      .clr             (clr),
      .samp_out_data   (samp_out_data),
      .samp_out_ch     (samp_out_ch),
      .samp_out_str    (samp_out_str),
      .samp_out_primed (samp_out_primed),
      .err_ch          (err_ch)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference state: every sample seen per channel since the last clr/reset.
   logic signed [7:0] hist [NCH][$];
   int                m_model;
   bit                err_m;
   bit                exp_str;
   logic signed [7:0] exp_data;
   logic        [1:0] exp_ch;
   bit                exp_primed;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) hist[c].delete();
      m_model    = MMAX;
      err_m      = 1'b0;
      exp_str    = 1'b0;
      exp_data   = '0;
      exp_ch     = '0;
      exp_primed = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".str"}, 32'(samp_out_str), 32'(exp_str));
      chk({tag, ".data"}, 32'(samp_out_data), 32'(exp_data));
      chk({tag, ".ch"}, 32'(samp_out_ch), 32'(exp_ch));
      chk({tag, ".primed"}, 32'(samp_out_primed), 32'(exp_primed));
      chk({tag, ".err"}, 32'(err_ch), 32'(err_m));
   endtask

   // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input string tag, input bit str, input logic [1:0] ch,
                       input logic signed [7:0] d, input bit c, input logic [2:0] sel);
      int                n;
      logic signed [7:0] prev;
      @(negedge clk);
      samp_inp_str  = str;
      samp_inp_ch   = ch;
      samp_inp_data = d;
      clr           = c;
      cic_m_sel     = sel;
      @(posedge clk);
      #1;
      if (c) begin
         for (int i = 0; i < NCH; i++) hist[i].delete();
         err_m   = 1'b0;
         m_model = (sel == 0) ? 1 : ((int'(sel) > MMAX) ? MMAX : int'(sel));
         exp_str = 1'b0;
      end else if (str && int'(ch) >= NCH) begin
         err_m   = 1'b1;
         exp_str = 1'b0;
      end else if (str) begin
         n          = hist[ch].size();
         prev       = (n >= m_model) ? hist[ch][n - m_model] : 8'sd0;
         exp_data   = d - prev;
         exp_primed = (n >= m_model);
         exp_ch     = ch;
         exp_str    = 1'b1;
         hist[ch].push_back(d);
      end else begin
         exp_str = 1'b0;
      end
      check_outputs(tag);
   endtask

   initial begin
      model_reset();
      #12;
      check_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // Delay after reset is MMAX: five passthroughs, then x[5]-x[0].
      for (int i = 0; i < 7; i++) step("m5_boot", 1'b1, 2'd0, 8'(3 * i + 1), 1'b0, 3'd0);

      // M=1 via sel=0 clamp: 10,15,15,7 -> 10,5,0,-8.
      step("clr_m1", 1'b0, 2'd0, 8'sd0, 1'b1, 3'd0);
      step("m1_a", 1'b1, 2'd0, 8'sd10, 1'b0, 3'd6);
      step("m1_b", 1'b1, 2'd0, 8'sd15, 1'b0, 3'd6);
      step("m1_c", 1'b1, 2'd0, 8'sd15, 1'b0, 3'd6);
      step("m1_d", 1'b1, 2'd0, 8'sd7, 1'b0, 3'd6);
      // 8-bit wrap: -128 then 127 -> -128, -1.
      step("wrap_a", 1'b1, 2'd1, -8'sd128, 1'b0, 3'd0);
      step("wrap_b", 1'b1, 2'd1, 8'sd127, 1'b0, 3'd0);
      step("idle", 1'b0, 2'd0, 8'sd0, 1'b0, 3'd0);

      // M=2 interleave of ch0 and ch2.
      step("clr_m2", 1'b0, 2'd0, 8'sd0, 1'b1, 3'd2);
      for (int i = 0; i < 3; i++) begin
         step("il_ch0", 1'b1, 2'd0, 8'(10 * (i + 1)), 1'b0, 3'd0);
         step("il_ch2", 1'b1, 2'd2, -8'sd5, 1'b0, 3'd0);
      end

      // M=3: 1,2,4,8,16 -> 1,2,4,7,14.
      step("clr_m3", 1'b0, 2'd0, 8'sd0, 1'b1, 3'd3);
      for (int i = 0; i < 5; i++) step("m3", 1'b1, 2'd0, 8'(1 << i), 1'b0, 3'd1);

      // sel=7 clamps to MMAX.
      step("clr_m7", 1'b0, 2'd0, 8'sd0, 1'b1, 3'd7);
      for (int i = 0; i < 7; i++) step("m7", 1'b1, 2'd1, 8'(5 + 2 * i * i), 1'b0, 3'd0);

      // clr beats a simultaneous strobe.
      step("clr_str", 1'b1, 2'd0, 8'sd50, 1'b1, 3'd2);
      step("after_clr", 1'b1, 2'd0, 8'sd60, 1'b0, 3'd0);

      // Invalid channel sets a sticky error without disturbing traffic.
      step("bad_ch", 1'b1, 2'd3, 8'sd99, 1'b0, 3'd0);
      step("sticky_a", 1'b1, 2'd0, 8'sd70, 1'b0, 3'd0);
      step("sticky_b", 1'b1, 2'd1, 8'sd71, 1'b0, 3'd0);
      step("sticky_c", 1'b0, 2'd0, 8'sd0, 1'b0, 3'd0);
      step("err_clr", 1'b0, 2'd0, 8'sd0, 1'b1, 3'd4);

      // Random traffic with occasional invalid channels and clears.
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
              8'($urandom), ($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)));
      end

      // Asynchronous reset mid-stream.
      @(negedge clk);
      samp_inp_str  = 1'b1;
      samp_inp_ch   = 2'd1;
      samp_inp_data = 8'sd33;
      clr           = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      @(negedge clk);
      samp_inp_str = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      step("post_rst_a", 1'b1, 2'd1, 8'sd44, 1'b0, 3'd0);
      step("post_rst_b", 1'b1, 2'd1, -8'sd20, 1'b0, 3'd0);
      step("post_rst_idle", 1'b0, 2'd0, 8'sd0, 1'b0, 3'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
